// File: rtl/count_rr_scheduler.sv
// count_rr_scheduler: round-robin arbiter that lends one shared CW-bit
// wrap-around counter to NREQ requesters for bursts of len+1 advances.
// Optional build macro: COUNT_RR_SCHED_ABORT_EN lets the granted requester
// cut its burst short by dropping req during RUN.
module count_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int CW   = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   len,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 cnt_en,
  output logic [CW-1:0]        cnt_val,
  output logic                 busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rem_q, rem_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;

  logic [PW-1:0]     win_c;
  logic [PW-1:0]     ptr_nxt;
  logic              abort_c;

  // Rotating-priority search: scan downward so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    win_c = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req[idx]) win_c = PW'(idx);
    end
  end

  assign ptr_nxt = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;

`ifdef COUNT_RR_SCHED_ABORT_EN
  assign abort_c = ~req[win_q];
`else
  assign abort_c = 1'b0;
`endif

  // Next-state / output decode for the IDLE -> RUN -> DONE burst sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d        = '0;
          gnt_d[win_c] = 1'b1;
          rem_d        = len[int'(win_c)*CW +: CW];
          win_d        = win_c;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        // Counter advances on every RUN edge, including an aborting one.
        cnt_d = cnt_q + 1'b1;
        if (abort_c) begin
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          state_d = S_IDLE;
        end else if (rem_q == '0) begin
          done_d[win_q] = 1'b1;
          state_d       = S_DONE;
        end else begin
          rem_d = rem_q - 1'b1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = ptr_nxt;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, burst is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign cnt_val = cnt_q;
  assign cnt_en  = (state_q == S_RUN);
  assign busy    = (state_q != S_IDLE);

endmodule
